// File: rtl/cpu_exec_ctrl.sv
// Execution controller: splits clkX4 into 4-phase CPU cycles, debounces the panel
// halt/clear/step inputs and drives cpuEn/cpuRst. Optional macro: CPU_EXEC_CYCLE_COUNTER_EN.
module cpu_exec_ctrl #(
  parameter int DEBOUNCE_LEN     = 16,
  parameter int CLEAR_CPU_CYCLES = 2
) (
  input  logic        clkX4,
  input  logic        rst,
  input  logic        sigCH,
  input  logic        sigCE,
  input  logic        sigCP,
  output logic        cpuEn,
  output logic        cpuRst,
  output logic [1:0]  phase,
  output logic        halted,
  output logic [2:0]  ctrlState,
  output logic [31:0] cycleCount
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HALT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

  localparam int            DW      = $clog2(DEBOUNCE_LEN);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LEN - 1);
  localparam int            CW      = $clog2(CLEAR_CPU_CYCLES + 2);
  localparam logic [CW-1:0] CLR_TGT = CW'(CLEAR_CPU_CYCLES);
  localparam logic [CW-1:0] CLR_PRE = CW'(CLEAR_CPU_CYCLES - 1);

  // bit 0 = halt switch, bit 1 = clear button, bit 2 = step button
  logic [2:0]    w_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_db;
  logic [DW-1:0] r_db_cnt [3];
  logic          r_cp_prev;
  logic [1:0]    r_phase;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_clr_cnt;
  logic [CW-1:0] w_clr_nxt;
  logic [CW-1:0] w_clr_inc;
  logic          r_step_pend;
  logic          w_pend_nxt;

  logic          w_ch_db;
  logic          w_ce_db;
  logic          w_step_evt;
  logic          w_boundary;
  logic          w_en_nxt;
  logic          w_rst_nxt;
  logic          w_halted_nxt;

  logic          r_cpu_en;
  logic          r_cpu_rst;
  logic          r_halted;

  assign w_raw      = {sigCP, sigCE, sigCH};
  assign w_ch_db    = r_db[0];
  assign w_ce_db    = r_db[1];
  assign w_step_evt = r_cp_prev & ~r_db[2];
  assign w_boundary = (r_phase == 2'd3);
  assign w_clr_inc  = r_clr_cnt + CW'(1);

  // Two-flop synchronizers for the raw panel inputs
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: flip only after DEBOUNCE_LEN consecutive differing samples
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_db      <= 3'b111;
      r_cp_prev <= 1'b1;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_cp_prev <= r_db[2];
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // FSM state register, clear-cycle counter, pending step flag and phase
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_clr_cnt   <= '0;
      r_step_pend <= 1'b0;
      r_phase     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_nxt;
      r_step_pend <= w_pend_nxt;
      r_phase     <= r_phase + 2'd1;
    end
  end

  // Next-state logic; transitions only at CPU-cycle boundaries, CLEAR first
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_cnt;
    w_pend_nxt  = r_step_pend;
    case (r_state)
      ST_INIT: begin
        w_pend_nxt = 1'b0;
        if (w_boundary) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = CLR_PRE;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN: begin
        w_pend_nxt = 1'b0;
        if (w_boundary && !w_ce_db) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = '0;
        end else if (w_boundary && !w_ch_db) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (w_step_evt) begin
          w_pend_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_step_pend;
        end
        if (w_boundary && !w_ce_db) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else if (w_boundary && w_ch_db) begin
          w_state_nxt = ST_RUN;
          w_pend_nxt  = 1'b0;
        end else if (w_boundary && r_step_pend) begin
          w_state_nxt = ST_STEP;
        end else begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_STEP: begin
        if (w_boundary) begin
          w_pend_nxt = 1'b0;
          if (!w_ce_db) begin
            w_state_nxt = ST_CLEAR;
            w_clr_nxt   = '0;
          end else if (w_ch_db) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_HALT;
          end
        end else begin
          w_state_nxt = ST_STEP;
        end
      end
      ST_CLEAR: begin
        w_pend_nxt = 1'b0;
        if (w_boundary && (w_clr_inc >= CLR_TGT) && w_ce_db) begin
          w_state_nxt = w_ch_db ? ST_RUN : ST_HALT;
        end else if (w_boundary) begin
          w_clr_nxt = (r_clr_cnt >= CLR_TGT) ? r_clr_cnt : w_clr_inc;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_clr_nxt   = '0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Output decode: enable is set on the edge where phase becomes 3
  always_comb begin
    w_en_nxt     = 1'b0;
    w_rst_nxt    = 1'b1;
    w_halted_nxt = 1'b0;
    if ((r_phase == 2'd2) && ((r_state == ST_RUN) || (r_state == ST_STEP))) begin
      w_en_nxt = 1'b1;
    end else begin
      w_en_nxt = 1'b0;
    end
    if ((w_state_nxt == ST_INIT) || (w_state_nxt == ST_CLEAR)) begin
      w_rst_nxt = 1'b0;
    end else begin
      w_rst_nxt = 1'b1;
    end
    if ((w_state_nxt == ST_HALT) || (w_state_nxt == ST_STEP)) begin
      w_halted_nxt = 1'b1;
    end else begin
      w_halted_nxt = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_cpu_en  <= 1'b0;
      r_cpu_rst <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_cpu_en  <= w_en_nxt;
      r_cpu_rst <= w_rst_nxt;
      r_halted  <= w_halted_nxt;
    end
  end

  assign cpuEn     = r_cpu_en;
  assign cpuRst    = r_cpu_rst;
  assign halted    = r_halted;
  assign phase     = r_phase;
  assign ctrlState = r_state;

`ifdef CPU_EXEC_CYCLE_COUNTER_EN
  logic [31:0] r_cycle_cnt;

  // Issued-pulse counter, advancing together with cpuEn and zeroed while clearing
  always_ff @(posedge clkX4 or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= 32'd0;
    end else if (r_state == ST_CLEAR) begin
      r_cycle_cnt <= 32'd0;
    end else if (w_en_nxt) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end else begin
      r_cycle_cnt <= r_cycle_cnt;
    end
  end

  assign cycleCount = r_cycle_cnt;
`else
  assign cycleCount = 32'd0;
`endif

endmodule
